// File: rtl/i2c_seq_pkg.sv
// Shared constants and types for the I2C burst sequencer: WB register map,
// controller command encodings, status bit positions, response codes and FSM states.
package i2c_seq_pkg;

    localparam logic [3:0] WB_STS0 = 4'd0;
    localparam logic [3:0] WB_STS1 = 4'd1;
    localparam logic [3:0] WB_ADDR = 4'd2;
    localparam logic [3:0] WB_CMD  = 4'd3;
    localparam logic [3:0] WB_DATA = 4'd4;
    localparam logic [3:0] WB_LEN  = 4'd5;

    localparam logic [7:0] CMD_WR_STOP = 8'h0D;
    localparam logic [7:0] CMD_WR      = 8'h05;
    localparam logic [7:0] CMD_RD_STOP = 8'h0B;
    localparam logic [7:0] CMD_STOP    = 8'h08;

    localparam int STS0_BUSY  = 0;
    localparam int STS0_NACK  = 3;
    localparam int STS1_EMPTY = 6;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_NACK    = 2'b01,
        ERR_TIMEOUT = 2'b10,
        ERR_LEN     = 2'b11
    } rsp_err_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LD_DEV,
        S_LD_RADDR,
        S_LD_WDATA,
        S_CMD,
        S_POLL,
        S_LD_LEN,
        S_RD_STS1,
        S_RD_DATA,
        S_STOP,
        S_RESP
    } state_e;

endpackage

// File: rtl/i2c_wb_access.sv
// Single-outstanding WB access engine: issues a one-cycle read or write pulse and
// reports completion once wb_done (and, for reads, wb_data_in_valid) has been seen.
module i2c_wb_access (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rnw,
    input  logic [3:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       wb_read,
    output logic       wb_write,
    output logic [3:0] wb_address,
    output logic [7:0] wb_data_out,
    input  logic [7:0] wb_data_in,
    input  logic       wb_data_in_valid,
    input  logic       wb_done
);

    logic       rnw_q;
    logic       got_done;
    logic       got_valid;
    logic [7:0] rdata_q;

    // Done and read data may arrive in either order or together.
    assign done  = busy && (got_done || wb_done) && (!rnw_q || got_valid || wb_data_in_valid);
    assign rdata = wb_data_in_valid ? wb_data_in : rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy        <= 1'b0;
            rnw_q       <= 1'b0;
            got_done    <= 1'b0;
            got_valid   <= 1'b0;
            rdata_q     <= 8'h00;
            wb_read     <= 1'b0;
            wb_write    <= 1'b0;
            wb_address  <= 4'h0;
            wb_data_out <= 8'h00;
        end else begin
            wb_read  <= 1'b0;
            wb_write <= 1'b0;
            if (start && !busy) begin
                busy        <= 1'b1;
                rnw_q       <= rnw;
                got_done    <= 1'b0;
                got_valid   <= 1'b0;
                wb_read     <= rnw;
                wb_write    <= !rnw;
                wb_address  <= addr;
                wb_data_out <= wdata;
            end else if (done) begin
                busy      <= 1'b0;
                got_done  <= 1'b0;
                got_valid <= 1'b0;
            end else if (busy) begin
                if (wb_done)
                    got_done <= 1'b1;
                if (wb_data_in_valid) begin
                    got_valid <= 1'b1;
                    rdata_q   <= wb_data_in;
                end
            end
        end
    end

endmodule

// File: rtl/i2c_burst_seq.sv
// I2C transaction sequencer: one request becomes the WB access sequence for the I2C
// controller. Optional NACK retry is enabled by defining I2C_SEQ_RETRY_EN.
module i2c_burst_seq
    import i2c_seq_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR       = 7'h1A,
    parameter int         REG_ADDR_BYTES = 1,
    parameter int         MAX_BYTES      = 2,
    parameter int         POLL_TIMEOUT   = 4096,
    parameter int         START_POLLS    = 4,
    parameter int         RETRY_MAX      = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_rnw,
    input  logic [8*REG_ADDR_BYTES-1:0] req_reg_addr,
    input  logic [2:0]                  req_len,
    input  logic [8*MAX_BYTES-1:0]      req_wdata,
    output logic                        rsp_valid,
    output logic [1:0]                  rsp_err,
    output logic [8*MAX_BYTES-1:0]      rsp_rdata,
    output logic                        wb_read,
    output logic                        wb_write,
    output logic [3:0]                  wb_address,
    output logic [7:0]                  wb_data_out,
    input  logic [7:0]                  wb_data_in,
    input  logic                        wb_data_in_valid,
    input  logic                        wb_done
);

    localparam int TMO_W = $clog2(POLL_TIMEOUT + 1);
    localparam int SP_W  = $clog2(START_POLLS + 1);
    localparam int RT_W  = $clog2(RETRY_MAX + 2);
`ifdef I2C_SEQ_RETRY_EN
    localparam int RETRY_LIM = RETRY_MAX;
`else
    localparam int RETRY_LIM = 0;
`endif

    state_e   state, state_nx;
    rsp_err_e err_q, err_nx;

    logic                        rnw_q;
    logic [2:0]                  len_q;
    logic [8*REG_ADDR_BYTES-1:0] raddr_q, raddr_sh;
    logic [8*MAX_BYTES-1:0]      wdata_q, wdata_sh, rdata_q;
    logic [2:0]                  idx;
    logic                        second_cmd, phase_b;
    logic [SP_W-1:0]             zero_cnt;
    logic [TMO_W-1:0]            tmo_cnt;
    logic [RT_W-1:0]             retry_cnt;

    logic       acc_go, acc_start, acc_rnw, acc_busy, acc_done;
    logic [3:0] acc_addr;
    logic [7:0] acc_wdata, acc_rdata;
    logic       len_bad, tmo_hit, sts_busy, nack, poll_done, poll_prog, retry_ok;

    i2c_wb_access u_acc (
        .clk              (clk),
        .reset            (reset),
        .start            (acc_start),
        .rnw              (acc_rnw),
        .addr             (acc_addr),
        .wdata            (acc_wdata),
        .busy             (acc_busy),
        .done             (acc_done),
        .rdata            (acc_rdata),
        .wb_read          (wb_read),
        .wb_write         (wb_write),
        .wb_address       (wb_address),
        .wb_data_out      (wb_data_out),
        .wb_data_in       (wb_data_in),
        .wb_data_in_valid (wb_data_in_valid),
        .wb_done          (wb_done)
    );

    assign len_bad   = (req_len == 3'd0) || (req_len > 3'(MAX_BYTES));
    assign tmo_hit   = (tmo_cnt == TMO_W'(POLL_TIMEOUT));
    assign sts_busy  = acc_rdata[STS0_BUSY];
    assign nack      = acc_rdata[STS0_NACK];
    // Phase A: busy seen high moves on; START_POLLS straight idle reads also mean done.
    assign poll_prog = !phase_b && sts_busy;
    assign poll_done = !sts_busy && (phase_b || zero_cnt == SP_W'(START_POLLS - 1));
    assign retry_ok  = (retry_cnt < RT_W'(RETRY_LIM));

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign rsp_err   = err_q;
    assign rsp_rdata = rdata_q;

    always_comb begin
        state_nx  = state;
        err_nx    = err_q;
        acc_go    = 1'b0;
        acc_rnw   = 1'b0;
        acc_addr  = WB_STS0;
        acc_wdata = 8'h00;
        case (state)
            S_IDLE: if (req_valid) begin
                state_nx = len_bad ? S_RESP : S_LD_DEV;
                err_nx   = len_bad ? ERR_LEN : ERR_OK;
            end
            S_LD_DEV: begin
                acc_go    = 1'b1;
                acc_addr  = WB_ADDR;
                acc_wdata = {1'b0, DEV_ADDR};
                if (acc_done) state_nx = S_LD_RADDR;
            end
            S_LD_RADDR: begin
                acc_go    = 1'b1;
                acc_addr  = WB_DATA;
                acc_wdata = raddr_sh[8*REG_ADDR_BYTES-1 -: 8];
                if (acc_done && idx == 3'(REG_ADDR_BYTES - 1))
                    state_nx = rnw_q ? S_CMD : S_LD_WDATA;
            end
            S_LD_WDATA: begin
                acc_go    = 1'b1;
                acc_addr  = WB_DATA;
                acc_wdata = wdata_sh[7:0];
                if (acc_done && idx == len_q - 3'd1) state_nx = S_CMD;
            end
            S_CMD: begin
                acc_go    = 1'b1;
                acc_addr  = WB_CMD;
                acc_wdata = !rnw_q ? CMD_WR_STOP : (second_cmd ? CMD_RD_STOP : CMD_WR);
                if (acc_done) state_nx = S_POLL;
            end
            S_POLL: begin
                acc_go  = 1'b1;
                acc_rnw = 1'b1;
                if (acc_done) begin
                    if (poll_done) begin
                        if (nack) begin
                            if (retry_ok) begin
                                state_nx = S_LD_DEV;
                            end else begin
                                state_nx = S_RESP;
                                err_nx   = ERR_NACK;
                            end
                        end else if (!rnw_q) begin
                            state_nx = S_RESP;
                        end else begin
                            state_nx = second_cmd ? S_RD_STS1 : S_LD_LEN;
                        end
                    end else if (!poll_prog && tmo_hit) begin
                        state_nx = S_STOP;
                    end
                end
            end
            S_LD_LEN: begin
                acc_go    = 1'b1;
                acc_addr  = WB_LEN;
                acc_wdata = {5'b0, len_q};
                if (acc_done) state_nx = S_CMD;
            end
            S_RD_STS1: begin
                acc_go   = 1'b1;
                acc_rnw  = 1'b1;
                acc_addr = WB_STS1;
                if (acc_done) begin
                    if (!acc_rdata[STS1_EMPTY]) state_nx = S_RD_DATA;
                    else if (tmo_hit)           state_nx = S_STOP;
                end
            end
            S_RD_DATA: begin
                acc_go   = 1'b1;
                acc_rnw  = 1'b1;
                acc_addr = WB_DATA;
                if (acc_done) state_nx = (idx == len_q - 3'd1) ? S_RESP : S_RD_STS1;
            end
            S_STOP: begin
                acc_go    = 1'b1;
                acc_addr  = WB_CMD;
                acc_wdata = CMD_STOP;
                if (acc_done) begin
                    state_nx = S_RESP;
                    err_nx   = ERR_TIMEOUT;
                end
            end
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        acc_start = acc_go && !acc_busy;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            err_q      <= ERR_OK;
            rdata_q    <= '0;
            idx        <= 3'd0;
            second_cmd <= 1'b0;
            phase_b    <= 1'b0;
            zero_cnt   <= '0;
            tmo_cnt    <= '0;
            retry_cnt  <= '0;
        end else begin
            state <= state_nx;
            err_q <= err_nx;
            if (state == S_IDLE && req_valid) begin
                rdata_q   <= '0;
                retry_cnt <= '0;
            end
            // Wait timer runs only while polling one condition; progress or leaving restarts it.
            if ((state == S_POLL || state == S_RD_STS1) && !(state == S_POLL && acc_done && poll_prog)) begin
                if (!tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end
            if (acc_done) begin
                case (state)
                    S_LD_DEV: begin
                        idx        <= 3'd0;
                        second_cmd <= 1'b0;
                    end
                    S_LD_RADDR, S_LD_WDATA:
                        idx <= (state_nx != state) ? 3'd0 : idx + 3'd1;
                    S_CMD: begin
                        phase_b  <= 1'b0;
                        zero_cnt <= '0;
                    end
                    S_POLL: begin
                        if (poll_prog) phase_b <= 1'b1;
                        if (!sts_busy) zero_cnt <= zero_cnt + 1'b1;
                        if (poll_done && !nack && rnw_q && !second_cmd) second_cmd <= 1'b1;
                        if (poll_done && nack && retry_ok) retry_cnt <= retry_cnt + 1'b1;
                    end
                    S_RD_DATA: begin
                        for (int i = 0; i < MAX_BYTES; i++)
                            if (idx == 3'(i)) rdata_q[8*i +: 8] <= acc_rdata;
                        idx <= idx + 3'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Request fields and byte shifters need no reset; they are loaded before use.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && req_valid) begin
            rnw_q   <= req_rnw;
            len_q   <= req_len;
            raddr_q <= req_reg_addr;
            wdata_q <= req_wdata;
        end
        if (acc_done) begin
            case (state)
                S_LD_DEV: begin
                    raddr_sh <= raddr_q;
                    wdata_sh <= wdata_q;
                end
                S_LD_RADDR: raddr_sh <= raddr_sh << 8;
                S_LD_WDATA: wdata_sh <= wdata_sh >> 8;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_burst_seq.sv
// Scoreboard bench for i2c_burst_seq: expected WB writes and responses are queued by
// the stimulus and popped by a monitor; a small WB slave model plays the controller.
module tb_i2c_burst_seq;

    localparam int MAXB = 2;
    localparam int TMO  = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_rnw = 1'b0;
    logic [7:0]        req_reg_addr = 8'h00;
    logic [2:0]        req_len = 3'd0;
    logic [8*MAXB-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic [1:0]        rsp_err;
    logic [8*MAXB-1:0] rsp_rdata;
    logic              wb_read, wb_write;
    logic [3:0]        wb_address;
    logic [7:0]        wb_data_out;
    logic [7:0]        wb_data_in = 8'h00;
    logic              wb_data_in_valid = 1'b0;
    logic              wb_done = 1'b0;

    i2c_burst_seq #(
        .DEV_ADDR(7'h1A), .REG_ADDR_BYTES(1), .MAX_BYTES(MAXB),
        .POLL_TIMEOUT(TMO), .START_POLLS(4), .RETRY_MAX(2)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
        .req_reg_addr(req_reg_addr), .req_len(req_len), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .wb_read(wb_read), .wb_write(wb_write), .wb_address(wb_address),
        .wb_data_out(wb_data_out), .wb_data_in(wb_data_in),
        .wb_data_in_valid(wb_data_in_valid), .wb_done(wb_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rsp_seen = 0;
    int wb_pulses = 0;
    int last_cmd_cyc = 0;
    logic [11:0] exp_wr[$];
    logic [17:0] exp_rsp[$];
    logic [7:0]  rd_bytes[$];
    logic nack_mode = 1'b0;
    logic stuck_mode = 1'b0;
    int sts0_n = 0;
    int sts1_n = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // WB slave: answers each access one cycle after its pulse.
    initial begin
        forever begin
            @(posedge clk); #1;
            wb_done = 1'b0;
            wb_data_in_valid = 1'b0;
            if (reset && (wb_read || wb_write)) begin
                wb_done = 1'b1;
                if (wb_write && wb_address == 4'd3) begin
                    sts0_n = 0;
                    sts1_n = 0;
                end
                if (wb_read) begin
                    wb_data_in_valid = 1'b1;
                    case (wb_address)
                        4'd0: begin
                            if (stuck_mode)       wb_data_in = 8'h01;
                            else if (sts0_n == 0) wb_data_in = 8'h00;
                            else if (sts0_n == 1) wb_data_in = 8'h01;
                            else                  wb_data_in = {4'b0, nack_mode, 3'b000};
                            sts0_n++;
                        end
                        4'd1: begin
                            wb_data_in = (sts1_n == 1) ? 8'h40 : 8'h00;
                            sts1_n++;
                        end
                        4'd4: wb_data_in = (rd_bytes.size() > 0) ? rd_bytes.pop_front() : 8'hEE;
                        default: wb_data_in = 8'h00;
                    endcase
                end
            end
        end
    end

    // Monitor: pops expected WB writes and responses as the DUT presents them.
    initial begin
        logic [11:0] ew;
        logic [17:0] er;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (wb_read || wb_write) wb_pulses++;
                if (wb_write) begin
                    if (exp_wr.size() == 0) begin
                        chk("unexpected_wb_write", {20'h0, wb_address, wb_data_out}, 32'hFFF);
                    end else begin
                        ew = exp_wr.pop_front();
                        chk("wb_write", {20'h0, wb_address, wb_data_out}, {20'h0, ew});
                    end
                    if (wb_address == 4'd3 && wb_data_out == 8'h08)
                        chk("timeout_window", 32'((cyc - last_cmd_cyc >= TMO) && (cyc - last_cmd_cyc <= TMO + 16)), 32'd1);
                    else if (wb_address == 4'd3)
                        last_cmd_cyc = cyc;
                end
                if (rsp_valid) begin
                    chk("ready_low_in_resp", {31'b0, req_ready}, 32'd0);
                    if (exp_rsp.size() == 0) begin
                        chk("unexpected_rsp", {14'h0, rsp_err, rsp_rdata}, 32'hFFFFFFFF);
                    end else begin
                        er = exp_rsp.pop_front();
                        chk("rsp", {14'h0, rsp_err, rsp_rdata}, {14'h0, er});
                    end
                    rsp_seen++;
                end
            end
        end
    end

    task automatic push_wr(input logic [3:0] a, input logic [7:0] d);
        exp_wr.push_back({a, d});
    endtask

    task automatic push_hdr(input logic [7:0] raddr);
        push_wr(4'd2, 8'h1A);
        push_wr(4'd4, raddr);
    endtask

    task automatic do_req(input logic rnw, input logic [7:0] raddr, input logic [2:0] len,
                          input logic [15:0] wdata, input logic [1:0] eerr, input logic [15:0] erdata);
        int s0;
        int n;
        exp_rsp.push_back({eerr, erdata});
        n = 0;
        while (!req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", {31'b0, req_ready}, 32'd1);
        s0 = rsp_seen;
        req_valid = 1'b1;
        req_rnw = rnw;
        req_reg_addr = raddr;
        req_len = len;
        req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_rnw = ~rnw;
        req_reg_addr = 8'hFF;
        req_len = 3'd7;
        req_wdata = '1;
        if (eerr == 2'b11) begin
            @(negedge clk);
            chk("len_err_next_cycle", {31'b0, rsp_valid}, 32'd1);
        end
        n = 0;
        while (rsp_seen == s0 && n < 5000) begin
            @(negedge clk); #1;
            n++;
        end
        chk("rsp_arrived", {31'b0, rsp_seen != s0}, 32'd1);
        @(negedge clk);
        chk("ready_after_resp", {30'b0, rsp_valid, req_ready}, 32'd1);
    endtask

    initial begin
        int p0;
        int attempts;
        int n;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {28'h0, req_ready, rsp_valid, wb_read, wb_write}, 32'h8);
        chk("reset_data", {10'h0, rsp_err, rsp_rdata, wb_address}, 32'h0);
        chk("reset_wbdata", {24'h0, wb_data_out}, 32'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single-byte write
        push_hdr(8'h04);
        push_wr(4'd4, 8'h55);
        push_wr(4'd3, 8'h0D);
        do_req(1'b0, 8'h04, 3'd1, 16'h0055, 2'b00, 16'h0000);

        // Two-byte read with an empty-FIFO status read before the second byte
        push_hdr(8'h07);
        push_wr(4'd3, 8'h05);
        push_wr(4'd5, 8'h02);
        push_wr(4'd3, 8'h0B);
        rd_bytes.push_back(8'hA1);
        rd_bytes.push_back(8'hB2);
        do_req(1'b1, 8'h07, 3'd2, 16'h0000, 2'b00, 16'hB2A1);

        // NACK on a two-byte write
`ifdef I2C_SEQ_RETRY_EN
        attempts = 3;
`else
        attempts = 1;
`endif
        nack_mode = 1'b1;
        for (int a = 0; a < attempts; a++) begin
            push_hdr(8'h10);
            push_wr(4'd4, 8'h22);
            push_wr(4'd4, 8'h33);
            push_wr(4'd3, 8'h0D);
        end
        do_req(1'b0, 8'h10, 3'd2, 16'h3322, 2'b01, 16'h0000);
        nack_mode = 1'b0;
        chk("nack_all_writes_seen", exp_wr.size(), 32'd0);

        // Busy stuck high: STOP then timeout error
        stuck_mode = 1'b1;
        push_hdr(8'h21);
        push_wr(4'd4, 8'h9C);
        push_wr(4'd3, 8'h0D);
        push_wr(4'd3, 8'h08);
        do_req(1'b0, 8'h21, 3'd1, 16'h009C, 2'b10, 16'h0000);
        stuck_mode = 1'b0;

        // Illegal lengths: no WB traffic
        p0 = wb_pulses;
        do_req(1'b0, 8'h01, 3'd0, 16'h1234, 2'b11, 16'h0000);
        do_req(1'b1, 8'h01, 3'(MAXB + 1), 16'h1234, 2'b11, 16'h0000);
        chk("len_bad_no_wb", wb_pulses - p0, 32'd0);

        // Reset while polling
        push_hdr(8'h30);
        push_wr(4'd4, 8'h77);
        push_wr(4'd3, 8'h0D);
        @(negedge clk);
        req_valid = 1'b1;
        req_rnw = 1'b0;
        req_reg_addr = 8'h30;
        req_len = 3'd1;
        req_wdata = 16'h0077;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (sts0_n < 1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reached_poll", {31'b0, sts0_n >= 1}, 32'd1);
        p0 = rsp_seen;
        #2 reset = 1'b0;
        #1;
        chk("mid_reset_outputs", {29'h0, wb_read, wb_write, req_ready}, 32'h1);
        chk("mid_reset_no_rsp", {31'b0, rsp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_rsp_after_reset", rsp_seen - p0, 32'd0);
        chk("ready_after_reset", {31'b0, req_ready}, 32'd1);

        // Recovery after reset
        push_hdr(8'h05);
        push_wr(4'd4, 8'hC3);
        push_wr(4'd3, 8'h0D);
        do_req(1'b0, 8'h05, 3'd1, 16'h00C3, 2'b00, 16'h0000);
        chk("all_writes_consumed", exp_wr.size(), 32'd0);
        chk("all_rsps_consumed", exp_rsp.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
